// File: rtl/clk_domain_seq.sv
`default_nettype none
// ============================================================================
// Module      : clk_domain_seq
// Description : Gate / reset / reprogram / relock sequencer for a PLL-fed
//               clock domain, with lock-timeout and lock-loss supervision.
// Revision    : 1.0
// ============================================================================
module clk_domain_seq #(
    parameter logic [3:0]  DEF_REF_DIV = 4'd1,
    parameter logic [11:0] DEF_FB_DIV  = 12'd50,
    parameter int          GATE_CYC    = 4,
    parameter int          RST_CYC     = 8,
    parameter int          MASK_CYC    = 16,
    parameter int          LOCK_TO     = 1024
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        cfg_valid_i,
    output logic        cfg_ready_o,
    input  logic [3:0]  cfg_ref_div_i,
    input  logic [11:0] cfg_fb_div_i,
    output logic [3:0]  pll_ref_div_o,
    output logic [11:0] pll_fb_div_o,
    input  logic        pll_locked_i,
    output logic        clk_en_o,
    output logic        rst_no,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_cfg_o,
    output logic        err_timeout_o,
    output logic        lock_lost_o
);

    localparam int c_cnt_w = $clog2(LOCK_TO + 1);

    localparam logic [c_cnt_w-1:0] c_gate_last = c_cnt_w'(GATE_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_rst_last  = c_cnt_w'(RST_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_mask      = c_cnt_w'(MASK_CYC);
    localparam logic [c_cnt_w-1:0] c_lock_last = c_cnt_w'(LOCK_TO - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_max   = '1;
    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);

    localparam logic [2:0] c_st_idle       = 3'd0;
    localparam logic [2:0] c_st_gate       = 3'd1;
    localparam logic [2:0] c_st_assert_rst = 3'd2;
    localparam logic [2:0] c_st_program    = 3'd3;
    localparam logic [2:0] c_st_wait_lock  = 3'd4;
    localparam logic [2:0] c_st_ungate     = 3'd5;
    localparam logic [2:0] c_st_error      = 3'd6;

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt;
    logic [3:0]         r_cap_ref;
    logic [11:0]        r_cap_fb;
    logic               w_hs;
    logic               w_cfg_bad;
    logic               w_hs_ok;
    logic               w_lock_loss;
    logic               w_timeout;

    assign w_hs        = cfg_valid_i && cfg_ready_o;
    assign w_cfg_bad   = (cfg_ref_div_i == 4'd0) || (cfg_fb_div_i == 12'd0);
    assign w_hs_ok     = w_hs && !w_cfg_bad;
    assign w_lock_loss = (r_state == c_st_idle) && !pll_locked_i;

    always_comb begin
        w_state_nxt = r_state;
        w_timeout   = 1'b0;
        case (r_state)
            c_st_idle: begin
                // A handshake wins over lock loss; a rejected one keeps IDLE.
                if (w_hs) begin
                    if (!w_cfg_bad) w_state_nxt = c_st_gate;
                end else if (!pll_locked_i) begin
                    w_state_nxt = c_st_gate;
                end
            end
            c_st_gate:       if (r_cnt == c_gate_last) w_state_nxt = c_st_assert_rst;
            c_st_assert_rst: if (r_cnt == c_rst_last)  w_state_nxt = c_st_program;
            c_st_program:    w_state_nxt = c_st_wait_lock;
            c_st_wait_lock: begin
                if ((r_cnt >= c_mask) && pll_locked_i) begin
                    w_state_nxt = c_st_ungate;
                end else if (r_cnt == c_lock_last) begin
                    w_state_nxt = c_st_error;
                    w_timeout   = 1'b1;
                end
            end
            c_st_ungate:     if (r_cnt == c_rst_last) w_state_nxt = c_st_idle;
            c_st_error:      if (w_hs_ok) w_state_nxt = c_st_gate;
            default:         w_state_nxt = c_st_idle;
        endcase
    end

    // Outputs are decoded from the next state so they line up with r_state.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state       <= c_st_wait_lock;
            r_cnt         <= '0;
            r_cap_ref     <= DEF_REF_DIV;
            r_cap_fb      <= DEF_FB_DIV;
            pll_ref_div_o <= DEF_REF_DIV;
            pll_fb_div_o  <= DEF_FB_DIV;
            clk_en_o      <= 1'b0;
            rst_no        <= 1'b0;
            busy_o        <= 1'b1;
            cfg_ready_o   <= 1'b0;
            done_o        <= 1'b0;
            err_cfg_o     <= 1'b0;
            err_timeout_o <= 1'b0;
            lock_lost_o   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt != r_state) begin
                r_cnt <= '0;
            end else if (r_cnt != c_cnt_max) begin
                r_cnt <= r_cnt + c_cnt_one;
            end

            if (w_hs_ok) begin
                r_cap_ref <= cfg_ref_div_i;
                r_cap_fb  <= cfg_fb_div_i;
            end

            if ((w_state_nxt == c_st_program) && (r_state != c_st_program)) begin
                pll_ref_div_o <= r_cap_ref;
                pll_fb_div_o  <= r_cap_fb;
            end

            clk_en_o    <= (w_state_nxt == c_st_idle) || (w_state_nxt == c_st_ungate);
            rst_no      <= (w_state_nxt == c_st_idle) || (w_state_nxt == c_st_gate);
            busy_o      <= (w_state_nxt != c_st_idle) && (w_state_nxt != c_st_error);
            cfg_ready_o <= (w_state_nxt == c_st_idle) || (w_state_nxt == c_st_error);
            done_o      <= (r_state == c_st_ungate) && (w_state_nxt == c_st_idle);
            err_cfg_o   <= w_hs && w_cfg_bad;

            if (w_hs_ok) begin
                err_timeout_o <= 1'b0;
            end else if (w_timeout) begin
                err_timeout_o <= 1'b1;
            end

            if (w_lock_loss) lock_lost_o <= 1'b1;
        end
    end

endmodule
`default_nettype wire
